muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M extension in the Execute stage.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op from the decode of Opcode 0110011 with Funct7 0000001.
- Runs a radix-2 shift-add multiplier or a restoring divider, one bit per cycle.
- Holds the pipeline via busy until a one-cycle done pulse presents the result to writeback.

---
 rtl/muldiv_seq.sv | 161 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : RV32M multi-cycle sequencer. Radix-2 shift-add multiply and
//               restoring divide, one bit per cycle, with a busy stall and a
//               single-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]   c_last = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_funct3;
    logic              r_neg;
    logic [XLEN-1:0]   r_oper;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_neg_in;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic              w_last;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_lo_fix;
    logic [XLEN-1:0]   w_hi_fix;
    logic [XLEN-1:0]   w_fin;

    assign busy_o   = (r_state != S_IDLE);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;

    assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_last   = (r_cnt == c_last);

    // Sign flags only count for the signed variants of each operand.
    assign w_s1 = rs1_i[XLEN-1] & ((funct3_i == 3'b001) | (funct3_i == 3'b010) |
                                   (funct3_i[2] & ~funct3_i[0]));
    assign w_s2 = rs2_i[XLEN-1] & ((funct3_i == 3'b001) | (funct3_i[2] & ~funct3_i[0]));
    assign w_abs1 = w_s1 ? -rs1_i : rs1_i;
    assign w_abs2 = w_s2 ? -rs2_i : rs2_i;
    // Remainder follows the dividend; product and quotient follow the sign xor.
    assign w_neg_in = (funct3_i[2] & funct3_i[1]) ? w_s1 : (w_s1 ^ w_s2);

    assign w_fast = funct3_i[2] & ((rs2_i == '0) |
                    (~funct3_i[0] & (rs1_i == c_min) & (rs2_i == '1)));
    assign w_fast_res = (rs2_i == '0) ? (funct3_i[1] ? rs1_i : '1)
                                      : (funct3_i[1] ? '0 : c_min);

    // Multiply: accumulate into the upper half, multiplier drains from the lower half.
    assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_oper} : '0);
    // Divide: upper half is the partial remainder, lower half the dividend/quotient.
    assign w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_oper};

    always_comb begin
        w_step = '0;
        if (r_state == S_MUL) begin
            w_step = {w_sum, r_acc[XLEN-1:1]};
        end else if (w_trial[XLEN]) begin
            w_step = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            w_step = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        w_prod_fix = r_neg ? -w_step : w_step;
        w_lo_fix   = r_neg ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
        w_hi_fix   = r_neg ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
        w_fin      = '0;
        if (r_state == S_MUL) begin
            w_fin = (r_funct3 == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        end else begin
            w_fin = r_funct3[1] ? w_hi_fix : w_lo_fix;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fast)           w_state_nxt = S_DONE;
                    else if (funct3_i[2]) w_state_nxt = S_DIV;
                    else                  w_state_nxt = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (flush_i)     w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_oper   <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_funct3 <= funct3_i[1:0];
                r_neg    <= w_neg_in;
                r_oper   <= funct3_i[2] ? w_abs2 : w_abs1;
                r_acc    <= {{XLEN{1'b0}}, (funct3_i[2] ? w_abs1 : w_abs2)};
                r_cnt    <= '0;
                if (w_fast) begin
                    r_result <= w_fast_res;
                end
            end else if ((r_state == S_MUL || r_state == S_DIV) && !flush_i) begin
                r_acc <= w_step;
                if (w_last) begin
                    r_result <= w_fin;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq: directed vectors, random
//               ops against an arithmetic model, and flush/busy/reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        sa = longint'({{32{a[31]}}, a});
        sb = longint'({{32{b[31]}}, b});
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (f3)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 33;
    endfunction

    // Issue one op, then count cycles after the accept edge until done_o.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
        @(posedge clk);
        #1;
        start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; funct3_i = 3'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_o) begin
                lat = n;
                break;
            end
        end
        res = result_o;
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int          lat;
        run_op(f3, a, b, res, lat);
        chk({name, "_result"}, res, exp_res);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'b0, done_o}, 32'h0);
        chk({name, "_busy_after"}, {31'b0, busy_o}, 32'h0);
        chk({name, "_result_hold"}, result_o, exp_res);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b, first_res;
        int          ndone, first_lat;
        bit          check_idle;

        rst_n = 1'b0; start_i = 1'b0; funct3_i = '0; rs1_i = '0; rs2_i = '0; flush_i = 1'b0;

        vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2]  = '{3'b011, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 33};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        vecs[6]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[7]  = '{3'b101, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 33};
        vecs[8]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
        vecs[9]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[10] = '{3'b110, 32'd5,        32'd0,        32'h00000005, 1};
        vecs[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[13] = '{3'b111, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1};

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy_o}, 32'h0);
        chk("reset_done", {31'b0, done_o}, 32'h0);
        chk("reset_result", result_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'b0, busy_o}, 32'h0);
        chk("idle_done", {31'b0, done_o}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                  vecs[i].exp_res, vecs[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            do_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b),
                  ref_lat(f3, a, b));
        end

        // Flush mid-multiply: no done, result keeps the previous value.
        do_op("pre_flush", 3'b101, 32'hFFFFFFFF, 32'h2, 32'h7FFFFFFF, 33);
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'hFFFFFFFD;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush_busy_before", {31'b0, busy_o}, 32'h1);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy_after", {31'b0, busy_o}, 32'h0);
        chk("flush_result_kept", result_o, 32'h7FFFFFFF);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        chk("flush_no_done", 32'(ndone), 32'h0);
        do_op("post_flush", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);

        // start while busy and start during DONE are both ignored.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'hFFFFFFFD;
        @(posedge clk);
        #1 start_i = 1'b0;
        ndone = 0; first_lat = -1; first_res = '0; check_idle = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (check_idle) begin
                chk("start_in_done_ignored", {31'b0, busy_o}, 32'h0);
                check_idle = 1'b0;
            end
            if (n == 5) begin
                start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd0;
            end
            if (done_o) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = n; first_res = result_o; check_idle = 1'b1;
                    start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd5; rs2_i = 32'd0;
                end
            end
        end
        start_i = 1'b0;
        chk("busy_start_single_done", 32'(ndone), 32'h1);
        chk("busy_start_latency", 32'(first_lat), 32'd33);
        chk("busy_start_result", first_res, 32'hFFFFFFEB);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b001; rs1_i = 32'h80000000; rs2_i = 32'h80000000;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'b0, busy_o}, 32'h0);
        chk("async_rst_done", {31'b0, done_o}, 32'h0);
        chk("async_rst_result", result_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        chk("rst_discarded_op", 32'(ndone), 32'h0);
        do_op("post_reset", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
